// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_XFER,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    // Start + 8 data + parity + stop.
    localparam int unsigned PS2_FRAME_BITS = 11;
    // Device-clock fall on which the device drives its ACK bit.
    localparam int unsigned PS2_ACK_FALL   = 11;

    // PS/2 uses odd parity over the data byte.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions the raw PS/2 pins: 2-flop synchronizers on clock and data,
// a consecutive-sample glitch filter on the clock, and a falling-edge pulse.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_f,
    output logic fall,
    output logic data_s
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             clk_s1_q, clk_s1_d;
    logic             clk_s2_q, clk_s2_d;
    logic             data_s1_q, data_s1_d;
    logic             data_s2_q, data_s2_d;
    logic             clk_f_q, clk_f_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronizer shift and filter: flip clk_f after FILTER_LEN differing samples.
    always_comb begin
        clk_s1_d  = clk_in;
        clk_s2_d  = clk_s1_q;
        data_s1_d = data_in;
        data_s2_d = data_s1_q;
        clk_f_d   = clk_f_q;
        fall_d    = 1'b0;
        cnt_d     = '0;
        if (clk_s2_q != clk_f_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                clk_f_d = clk_s2_q;
                fall_d  = clk_f_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Register update; idle PS/2 lines are high, so flops reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
            clk_f_q   <= 1'b1;
            fall_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            clk_s1_q  <= clk_s1_d;
            clk_s2_q  <= clk_s2_d;
            data_s1_q <= data_s1_d;
            data_s2_q <= data_s2_d;
            clk_f_q   <= clk_f_d;
            fall_q    <= fall_d;
            cnt_q     <= cnt_d;
        end
    end

    assign clk_f  = clk_f_q;
    assign fall   = fall_q;
    assign data_s = data_s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, clocked-out frame,
// ACK check and timeout, driving the open-drain lines via output enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 2700,
    parameter int unsigned TIMEOUT_CYCLES = 405000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned CYC_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
    localparam int unsigned SHIFT_W = PS2_FRAME_BITS - 1;

    ps2_state_t         state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic clk_f, fall, data_s;
    logic accept, timed, expired;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_line_filter (
        .clk     (clk),
        .reset   (reset),
        .clk_in  (ps2_clk_in),
        .data_in (ps2_data_in),
        .clk_f   (clk_f),
        .fall    (fall),
        .data_s  (data_s)
    );

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign timed    = (state_q == ST_XFER) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
    assign expired  = timed && (cyc_q == '0);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        cyc_d     = cyc_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (timed && !expired) begin
            cyc_d = cyc_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                if (accept) begin
                    shift_d   = {1'b1, ps2_odd_parity(tx_data), tx_data};
                    bit_cnt_d = '0;
                    cyc_d     = CYC_W'(INHIBIT_CYCLES - 1);
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cyc_q == '0) begin
                    data_oe_d = 1'b1;
                    state_d   = ST_RTS;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            ST_RTS: begin
                data_oe_d = 1'b1;
                cyc_d     = CYC_W'(TIMEOUT_CYCLES - 1);
                state_d   = ST_XFER;
            end
            ST_XFER: begin
                if (fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[SHIFT_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'(PS2_ACK_FALL - 2)) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (fall) begin
                    done_d    = ~data_s;
                    error_d   = data_s;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (clk_f && data_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout takes priority over a same-cycle fall. In WAIT_IDLE the
        // byte has already reported done/error, so only the lines are released.
        if (expired) begin
            state_d   = ST_IDLE;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            error_d   = (state_q != ST_WAIT_IDLE);
        end

        clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_RTS);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cyc_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_q     <= cyc_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH = 30;
    localparam int TMO = 3000;
    localparam int FLT = 8;
    localparam int H   = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_err   = 0;
    int n_both  = 0;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN(FLT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // Pulse counters for done/error.
    always @(negedge clk) begin
        if (done)          n_done++;
        if (error)         n_err++;
        if (done && error) n_both++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Device side: wait for request-to-send, then clock out n_falls falls.
    task automatic device_frame(input int n_falls, input bit ack_low, input bit glitch,
                                output logic [7:0] bits, output logic start,
                                output logic par, output logic stop, output bit ok);
        int   t;
        logic line;
        ok = 1'b1; bits = '0; start = 1'b1; par = 1'b0; stop = 1'b0; t = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1)) begin
            @(negedge clk);
            t++;
            if (t > 5000) begin
                ok = 1'b0;
                return;
            end
        end
        start = ps2_data_in;
        repeat (H) @(negedge clk);
        for (int i = 1; i <= n_falls; i++) begin
            if (i == 11 && ack_low) dev_data = 1'b0;
            dev_clk = 1'b0;
            if (glitch) begin
                repeat (10) @(negedge clk);
                dev_clk = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk = 1'b0;
                repeat (H - 13) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            dev_clk = 1'b1;
            if (glitch) begin
                repeat (10) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (H - 13) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            line = ps2_data_in;
            if (i <= 8)       bits[i-1] = line;
            else if (i == 9)  par = line;
            else if (i == 10) stop = line;
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!tx_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(tx_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack_low;
        bit         glitch;
        logic [7:0] exp_bits;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    initial begin
        vec_t       vecs[4];
        logic [7:0] bits;
        logic       start, par, stop;
        bit         ok;
        int         d0, e0, cnt;

        // 0xED: bits LSB-first 1,0,1,1,0,1,1,1 ; six ones -> parity 1
        vecs[0] = '{8'hED, 1'b1, 1'b0, 8'b1110_1101, 1'b1, 1, 0};
        // 0xF4: five ones -> parity 0 ; device leaves data high at ACK
        vecs[1] = '{8'hF4, 1'b0, 1'b0, 8'b1111_0100, 1'b0, 0, 1};
        // 0x55 with clock glitches: four ones -> parity 1
        vecs[2] = '{8'h55, 1'b1, 1'b1, 8'b0101_0101, 1'b1, 1, 0};
        // 0x01: one one -> parity 0
        vecs[3] = '{8'h01, 1'b1, 1'b0, 8'b0000_0001, 1'b0, 1, 0};

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_clk_oe",   32'(ps2_clk_oe),  32'd0);
        check("rst_data_oe",  32'(ps2_data_oe), 32'd0);
        check("rst_done",     32'(done),        32'd0);
        check("rst_error",    32'(error),       32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_tx_ready", 32'(tx_ready),    32'd1);

        for (int v = 0; v < 4; v++) begin
            d0 = n_done; e0 = n_err;
            tx_data  = vecs[v].data;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = 8'hA5;
            device_frame(11, vecs[v].ack_low, vecs[v].glitch, bits, start, par, stop, ok);
            check($sformatf("v%0d_rts_seen", v), 32'(ok),    32'd1);
            check($sformatf("v%0d_start", v),    32'(start), 32'd0);
            check($sformatf("v%0d_bits", v),     32'(bits),  32'(vecs[v].exp_bits));
            check($sformatf("v%0d_parity", v),   32'(par),   32'(vecs[v].exp_par));
            check($sformatf("v%0d_stop", v),     32'(stop),  32'd1);
            wait_ready($sformatf("v%0d_ready", v));
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_done_cnt", v), 32'(n_done - d0), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_err_cnt", v),  32'(n_err - e0),  32'(vecs[v].exp_err));
        end

        // Back-to-back 0xFF then 0x00 with tx_valid held high.
        d0 = n_done; e0 = n_err;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h00;
        device_frame(11, 1'b1, 1'b0, bits, start, par, stop, ok);
        check("b2b0_bits",   32'(bits), 32'h0000_00FF);
        check("b2b0_parity", 32'(par),  32'd1);
        cnt = 0;
        while (!tx_ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_idle_seen", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("b2b1_busy", 32'(busy), 32'd1);
        device_frame(11, 1'b1, 1'b0, bits, start, par, stop, ok);
        check("b2b1_bits",   32'(bits), 32'h0000_0000);
        check("b2b1_parity", 32'(par),  32'd1);
        wait_ready("b2b1_ready");
        repeat (5) @(negedge clk);
        check("b2b_done_cnt", 32'(n_done - d0), 32'd2);
        check("b2b_err_cnt",  32'(n_err - e0),  32'd0);

        // Device never clocks: inhibit length, then timeout.
        d0 = n_done; e0 = n_err;
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        cnt = 0;
        while (ps2_clk_oe && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("to_inhibit_len", 32'(cnt), 32'(INH + 1));
        cnt = 0;
        while (!error && cnt < TMO + 100) begin
            @(negedge clk);
            cnt++;
        end
        check("to_cycles",  32'(cnt),         32'(TMO));
        check("to_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("to_data_oe", 32'(ps2_data_oe), 32'd0);
        @(negedge clk);
        check("to_ready",   32'(tx_ready),    32'd1);
        check("to_done_cnt", 32'(n_done - d0), 32'd0);
        check("to_err_cnt",  32'(n_err - e0),  32'd1);

        // Reset after fall 5 of 0xED.
        d0 = n_done; e0 = n_err;
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        device_frame(5, 1'b1, 1'b0, bits, start, par, stop, ok);
        check("rmf_pre_data_oe", 32'(ps2_data_oe), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rmf_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("rmf_data_oe", 32'(ps2_data_oe), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rmf_ready", 32'(tx_ready), 32'd1);
        repeat (300) @(negedge clk);
        check("rmf_done_cnt", 32'(n_done - d0), 32'd0);
        check("rmf_err_cnt",  32'(n_err - e0),  32'd0);

        check("done_and_error_overlap", 32'(n_both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
